wave_gen: RTL

- Waveform sample source directly upstream of the SPI DAC sequencer; drives its 12-bit `data` input.
- Implements a phase-accumulator (DDS) generator with four waveforms, binary amplitude attenuation around mid-scale, and a programmable sample-rate prescaler.
- Control inputs are shadow-latched at phase wrap, so waveform, frequency and amplitude changes never land mid-period.

---
 rtl/wave_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/wave_gen.sv
// DDS waveform source feeding the SPI DAC sequencer: square/saw/triangle with attenuation.
// Define WAVE_GEN_SINE_LUT_EN to add a quarter-wave sine ROM on wave_sel=3.
module wave_gen #(
    parameter int ACC_W      = 16,
    parameter int SAMPLE_DIV = 64,
    parameter int DIV_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       wave_sel,
    input  logic [ACC_W-1:0] freq_word,
    input  logic [1:0]       amp_sh,
    output logic [11:0]      data,
    output logic             data_valid
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [11:0]      MID      = 12'h800;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [ACC_W-1:0] freq_s_q, freq_s_d;
    logic [1:0]       wave_s_q, wave_s_d;
    logic [1:0]       amp_s_q, amp_s_d;
    logic [11:0]      data_q, data_d;
    logic             valid_q, valid_d;

    logic             tick;
    logic [ACC_W:0]   sum;
    logic [11:0]      p;
    logic [11:0]      raw;

    function automatic logic [11:0] atten(input logic [11:0] r, input logic [1:0] sh);
        logic signed [12:0] dev;
        dev = $signed({1'b0, r}) - 13'sd2048;
        dev = dev >>> sh;
        return 12'(dev + 13'sd2048);
    endfunction

    assign tick = (state_q == RUN) && (div_q == DIV_LAST);
    assign sum  = {1'b0, phase_q} + {1'b0, freq_s_q};
    assign p    = sum[ACC_W-1 -: 12];

    always_comb begin
        raw = MID;
        unique case (wave_s_q)
            2'd0:    raw = p[11] ? 12'h000 : 12'hFFF;
            2'd1:    raw = p;
            2'd2:    raw = p[11] ? ~{p[10:0], 1'b0} : {p[10:0], 1'b0};
            default: raw = MID;
        endcase
    end

`ifdef WAVE_GEN_SINE_LUT_EN
    function automatic logic [10:0] sine_q(input int i);
        longint x, xa;
        x  = 2 * longint'(i) + 1;
        xa = x * (1024 - x);
        return 11'((2047 * 4 * xa) / (1310720 - xa));
    endfunction

    logic [10:0] rom [256];
    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = sine_q(i);
    end

    logic        sin_pend_q, sin_pend_d;
    logic        sin_neg_q, sin_neg_d;
    logic [1:0]  sin_amp_q, sin_amp_d;
    logic [10:0] rom_q, rom_d;
    logic [7:0]  sin_idx;
    logic [12:0] sin_hi;
    logic [11:0] sin_raw;

    assign sin_idx = p[10] ? ~p[9:2] : p[9:2];
    assign sin_hi  = 13'd2048 + {2'b00, rom_q};
    assign sin_raw = sin_neg_q ? 12'(13'd2048 - {2'b00, rom_q})
                   : (sin_hi[12] ? 12'hFFF : sin_hi[11:0]);
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        div_d    = div_q;
        freq_s_d = freq_s_q;
        wave_s_d = wave_s_q;
        amp_s_d  = amp_s_q;
        data_d   = data_q;
        valid_d  = 1'b0;
`ifdef WAVE_GEN_SINE_LUT_EN
        sin_pend_d = 1'b0;
        sin_neg_d  = sin_neg_q;
        sin_amp_d  = sin_amp_q;
        rom_d      = rom_q;
`endif
        unique case (state_q)
            IDLE: begin
                data_d  = MID;
                phase_d = '0;
                div_d   = '0;
                if (en) begin
                    state_d  = RUN;
                    freq_s_d = freq_word;
                    wave_s_d = wave_sel;
                    amp_s_d  = amp_sh;
                end
            end
            RUN: begin
                if (!en) begin
                    // Stop wins over a coincident tick: no sample, clean restart.
                    state_d = IDLE;
                    phase_d = '0;
                    div_d   = '0;
                    data_d  = MID;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
`ifdef WAVE_GEN_SINE_LUT_EN
                    if (sin_pend_q) begin
                        data_d  = atten(sin_raw, sin_amp_q);
                        valid_d = 1'b1;
                    end
`endif
                    if (tick) begin
                        phase_d = sum[ACC_W-1:0];
`ifdef WAVE_GEN_SINE_LUT_EN
                        if (wave_s_q == 2'd3) begin
                            sin_pend_d = 1'b1;
                            sin_neg_d  = p[11];
                            sin_amp_d  = amp_s_q;
                            rom_d      = rom[sin_idx];
                        end else begin
                            data_d  = atten(raw, amp_s_q);
                            valid_d = 1'b1;
                        end
`else
                        data_d  = atten(raw, amp_s_q);
                        valid_d = 1'b1;
`endif
                        // Reload at wrap, or every tick while stalled at zero rate.
                        if (sum[ACC_W] || (freq_s_q == '0)) begin
                            freq_s_d = freq_word;
                            wave_s_d = wave_sel;
                            amp_s_d  = amp_sh;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            div_q    <= '0;
            freq_s_q <= '0;
            wave_s_q <= '0;
            amp_s_q  <= '0;
            data_q   <= MID;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            freq_s_q <= freq_s_d;
            wave_s_q <= wave_s_d;
            amp_s_q  <= amp_s_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

`ifdef WAVE_GEN_SINE_LUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sin_pend_q <= 1'b0;
            sin_neg_q  <= 1'b0;
            sin_amp_q  <= '0;
            rom_q      <= '0;
        end else begin
            sin_pend_q <= sin_pend_d;
            sin_neg_q  <= sin_neg_d;
            sin_amp_q  <= sin_amp_d;
            rom_q      <= rom_d;
        end
    end
`endif

    assign data       = data_q;
    assign data_valid = valid_q;

endmodule
